// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU (start/done, registered result/flags, carry-in, iterative shift/rotate, shift-add MUL)
module alu_mc #(
  parameter int DATA_WIDTH = 8,
  parameter int SHAMT_W = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            func,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic                  carry_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic                  zero_flag,
  output logic                  negative_flag,
  output logic                  carry_flag,
  output logic                  overflow_flag
);
  localparam int W = DATA_WIDTH;
  localparam logic [3:0] F_ADD = 4'd0, F_SUB = 4'd1, F_AND = 4'd2, F_ADC = 4'd3, F_OR = 4'd4,
                         F_XOR = 4'd5, F_CPB = 4'd6, F_NOTB = 4'd7, F_SBC = 4'd8, F_SHL = 4'd9,
                         F_SHR = 4'd10, F_SAR = 4'd11, F_ROL = 4'd12, F_ROR = 4'd13, F_MUL = 4'd14,
                         F_RSV = 4'd15;
  localparam logic [SHAMT_W:0] C_ONE = (SHAMT_W+1)'(1);
  localparam logic [SHAMT_W:0] C_W = (SHAMT_W+1)'(W);
  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;
  state_t             r_state;
  logic [3:0]         r_func;
  logic [W-1:0]       r_a, r_b, r_acc;
  logic [SHAMT_W:0]   r_cnt;
  logic               w_sub, w_cin, w_co, w_c, w_v, w_so, w_is_sh, w_accept;
  logic [W-1:0]       w_bx, w_sum, w_res, w_sh, w_lo;
  logic [W:0]         w_ms;
  logic [SHAMT_W-1:0] w_amt;
  assign w_sub = func == F_SUB || func == F_SBC;
  assign w_cin = func == F_ADD ? 1'b0 : func == F_SUB ? 1'b1 : carry_in;
  assign w_bx = w_sub ? ~op_b : op_b;
  assign {w_co, w_sum} = {1'b0, op_a} + {1'b0, w_bx} + {{W{1'b0}}, w_cin};
  assign w_amt = op_b[SHAMT_W-1:0];
  assign w_is_sh = func >= F_SHL && func <= F_ROR;
  assign w_accept = start && r_state == IDLE;
  always_comb begin
    w_res = '0;
    w_c = 1'b0;
    w_v = 1'b0;
    case (func)
      F_ADD, F_SUB, F_ADC, F_SBC: begin
        w_res = w_sum;
        w_c = w_co;
        w_v = (op_a[W-1] == w_bx[W-1]) && (w_sum[W-1] != op_a[W-1]);
      end
      F_AND: w_res = op_a & op_b;
      F_OR: w_res = op_a | op_b;
      F_XOR: w_res = op_a ^ op_b;
      F_CPB: w_res = op_b;
      F_NOTB: w_res = ~op_b;
      F_SHL, F_SHR, F_SAR, F_ROL, F_ROR: w_res = op_a;
      default: w_res = '0;
    endcase
  end
  assign w_so = (r_func == F_SHL || r_func == F_ROL) ? r_a[W-1] : r_a[0];
  assign w_sh = r_func == F_SHL ? {r_a[W-2:0], 1'b0} :
                r_func == F_ROL ? {r_a[W-2:0], r_a[W-1]} :
                {r_func == F_ROR ? r_a[0] : r_func == F_SAR ? r_a[W-1] : 1'b0, r_a[W-1:1]};
  assign w_ms = {1'b0, r_acc} + (r_b[0] ? {1'b0, r_a} : {(W+1){1'b0}});
  assign w_lo = {w_ms[0], r_b[W-1:1]};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_func <= '0;
      r_a <= '0;
      r_b <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      result_hi <= '0;
      zero_flag <= 1'b0;
      negative_flag <= 1'b0;
      carry_flag <= 1'b0;
      overflow_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_func <= func;
          r_a <= op_a;
          r_b <= op_b;
          r_acc <= '0;
          if (func == F_MUL) begin
            r_cnt <= C_W;
            busy <= 1'b1;
            r_state <= MUL;
          end else if (w_is_sh && w_amt != '0) begin
            r_cnt <= {1'b0, w_amt};
            busy <= 1'b1;
            r_state <= SHIFT;
          end else begin
            result <= w_res;
            result_hi <= '0;
            zero_flag <= func != F_RSV && w_res == '0;
            negative_flag <= w_res[W-1];
            carry_flag <= w_c;
            overflow_flag <= w_v;
            done <= 1'b1;
          end
        end
        SHIFT: begin
          r_a <= w_sh;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == C_ONE) begin
            result <= w_sh;
            result_hi <= '0;
            zero_flag <= w_sh == '0;
            negative_flag <= w_sh[W-1];
            carry_flag <= w_so;
            overflow_flag <= 1'b0;
            done <= 1'b1;
            busy <= 1'b0;
            r_state <= IDLE;
          end
        end
        MUL: begin
          r_acc <= w_ms[W:1];
          r_b <= w_lo;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == C_ONE) begin
            result <= w_lo;
            result_hi <= w_ms[W:1];
            zero_flag <= w_ms[W:1] == '0 && w_lo == '0;
            negative_flag <= w_lo[W-1];
            carry_flag <= w_ms[W:1] != '0;
            overflow_flag <= 1'b0;
            done <= 1'b1;
            busy <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifndef SYNTHESIS
  logic r_live;
  always_ff @(posedge clk) r_live <= !rst && (w_accept || r_state != IDLE);
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(done && busy));
      assert (!done || r_live);
    end
  end
`endif
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc
module tb_alu_mc;
  logic clk = 0, rst = 1, start = 0, carry_in = 0;
  logic [3:0] func = 0;
  logic [7:0] op_a = 0, op_b = 0;
  logic busy, done, zero_flag, negative_flag, carry_flag, overflow_flag;
  logic [7:0] result, result_hi;
  int checks = 0, failures = 0, lat = 0, bc = 0, nd = 0, ld = 0;
  alu_mc #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .func(func), .op_a(op_a), .op_b(op_b),
    .carry_in(carry_in), .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .zero_flag(zero_flag), .negative_flag(negative_flag), .carry_flag(carry_flag),
    .overflow_flag(overflow_flag)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic outs(input string t, input logic [7:0] r, input logic [7:0] h,
                      input logic z, input logic n, input logic c, input logic v);
    chk({t, ".res"}, result, r);
    chk({t, ".hi"}, result_hi, h);
    chk({t, ".z"}, zero_flag, z);
    chk({t, ".n"}, negative_flag, n);
    chk({t, ".c"}, carry_flag, c);
    chk({t, ".v"}, overflow_flag, v);
  endtask
  task automatic run(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b, input logic ci);
    @(negedge clk);
    func = f;
    op_a = a;
    op_b = b;
    carry_in = ci;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    func = 4'd15;
    op_a = ~a;
    op_b = ~b;
    carry_in = ~ci;
    lat = 1;
    bc = 0;
    @(negedge clk);
    while (!done && lat < 40) begin
      if (busy) bc++;
      lat++;
      @(negedge clk);
    end
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    outs("reset", 8'h00, 8'h00, 0, 0, 0, 0);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    rst = 0;
    run(4'd0, 8'h7F, 8'h01, 0);
    outs("add", 8'h80, 8'h00, 0, 1, 0, 1);
    chk("add.lat", lat, 1);
    chk("add.busy", bc, 0);
    run(4'd1, 8'h05, 8'h05, 0);
    outs("sub", 8'h00, 8'h00, 1, 0, 1, 0);
    run(4'd3, 8'hFF, 8'h01, 1);
    outs("adc", 8'h01, 8'h00, 0, 0, 1, 0);
    run(4'd8, 8'h00, 8'h01, 1);
    outs("sbc_borrow", 8'hFF, 8'h00, 0, 1, 0, 0);
    run(4'd8, 8'h80, 8'h01, 1);
    outs("sbc_ovf", 8'h7F, 8'h00, 0, 0, 1, 1);
    run(4'd2, 8'hF0, 8'h3C, 1);
    outs("and", 8'h30, 8'h00, 0, 0, 0, 0);
    run(4'd4, 8'hF0, 8'h3C, 1);
    outs("or", 8'hFC, 8'h00, 0, 1, 0, 0);
    run(4'd6, 8'hF0, 8'h3C, 0);
    outs("copyb", 8'h3C, 8'h00, 0, 0, 0, 0);
    run(4'd7, 8'hF0, 8'h3C, 0);
    outs("notb", 8'hC3, 8'h00, 0, 1, 0, 0);
    run(4'd15, 8'hFF, 8'hFF, 1);
    outs("rsvd", 8'h00, 8'h00, 0, 0, 0, 0);
    chk("rsvd.lat", lat, 1);
    run(4'd13, 8'h81, 8'h01, 0);
    outs("ror", 8'hC0, 8'h00, 0, 1, 1, 0);
    chk("ror.lat", lat, 2);
    run(4'd9, 8'h81, 8'h03, 0);
    outs("shl", 8'h08, 8'h00, 0, 0, 0, 0);
    chk("shl.lat", lat, 4);
    chk("shl.busy", bc, 3);
    run(4'd10, 8'h9A, 8'h08, 0);
    outs("shr0", 8'h9A, 8'h00, 0, 1, 0, 0);
    chk("shr0.lat", lat, 1);
    chk("shr0.busy", bc, 0);
    run(4'd12, 8'h81, 8'h01, 0);
    outs("rol", 8'h03, 8'h00, 0, 0, 1, 0);
    run(4'd10, 8'h81, 8'h01, 0);
    outs("shr", 8'h40, 8'h00, 0, 0, 1, 0);
    run(4'd9, 8'h01, 8'h07, 0);
    outs("shl7", 8'h80, 8'h00, 0, 1, 0, 0);
    chk("shl7.lat", lat, 8);
    run(4'd14, 8'h0C, 8'h0A, 0);
    outs("mul_small", 8'h78, 8'h00, 0, 0, 0, 0);
    chk("mul_small.lat", lat, 9);
    run(4'd14, 8'h00, 8'h5A, 0);
    outs("mul_zero", 8'h00, 8'h00, 1, 0, 0, 0);
    run(4'd14, 8'h80, 8'h02, 0);
    outs("mul_hi", 8'h00, 8'h01, 0, 0, 1, 0);
    @(negedge clk);
    func = 4'd14;
    op_a = 8'hFF;
    op_b = 8'hFF;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    nd = 0;
    ld = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (ld == 0) ld = n;
      end
      start = (n == 3);
      if (n == 3) begin
        func = 4'd0;
        op_a = 8'h01;
        op_b = 8'h01;
      end
    end
    outs("mul_ff", 8'h01, 8'hFE, 0, 0, 1, 0);
    chk("mul_ff.ndone", nd, 1);
    chk("mul_ff.lat", ld, 9);
    @(negedge clk);
    func = 4'd14;
    op_a = 8'hFF;
    op_b = 8'hFF;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    outs("abort", 8'h00, 8'h00, 0, 0, 0, 0);
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort.nodone", nd, 0);
    run(4'd0, 8'h02, 8'h03, 0);
    outs("add_after_rst", 8'h05, 8'h00, 0, 0, 0, 0);
    chk("add_after_rst.lat", lat, 1);
    run(4'd11, 8'h80, 8'h07, 0);
    outs("sar", 8'hFF, 8'h00, 0, 1, 0, 0);
    chk("sar.lat", lat, 8);
    func = 4'd5;
    op_a = 8'hF0;
    op_b = 8'h3C;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    @(negedge clk);
    chk("b2b.done", done, 1);
    outs("b2b_xor", 8'hCC, 8'h00, 0, 1, 0, 0);
    @(negedge clk);
    chk("b2b.pulse", done, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
